// File: rtl/uart_frame_parser.sv
// uart_frame_parser: recovers payload bytes from 55 AA LEN DATA.. [CHK] frames in a uart_recv byte stream.
// Define UART_FRAME_CHKSUM_EN to add the trailing checksum byte (8-bit sum of LEN and payload).
module uart_frame_parser #(
  parameter int CLK_FREQ   = 65_000_000,
  parameter int MAX_LEN    = 16,
  parameter int TIMEOUT_US = 1000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       recv_done,
  input  logic [7:0] recv_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int TMO_CYCLES = CLK_FREQ / 1_000_000 * TIMEOUT_US;
  localparam int TMO_W      = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CYCLES - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
`ifdef UART_FRAME_CHKSUM_EN
  localparam logic [1:0] ERR_CHK  = 2'b10;
`endif
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR2 = 3'd1,
    ST_LEN  = 3'd2,
`ifdef UART_FRAME_CHKSUM_EN
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4
`else
    ST_DATA = 3'd3
`endif
  } state_t;

`ifdef UART_FRAME_CHKSUM_EN
  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction
`endif

  state_t           state_r, state_nx;
  logic [7:0]       len_r, len_nx;
  logic [7:0]       idx_r, idx_nx;
  logic [TMO_W-1:0] tmo_r, tmo_nx;
  logic             tmo_hit;
`ifdef UART_FRAME_CHKSUM_EN
  logic [7:0]       sum_r, sum_nx;
`endif
  logic             valid_nx, last_nx, done_nx, err_nx;
  logic [7:0]       data_nx;
  logic [1:0]       code_nx;

  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo_hit = (state_r != ST_IDLE) && !recv_done && (tmo_r == TMO_LAST);

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_nx = state_r;
    len_nx   = len_r;
    idx_nx   = idx_r;
`ifdef UART_FRAME_CHKSUM_EN
    sum_nx   = sum_r;
`endif
    valid_nx = 1'b0;
    data_nx  = 8'h00;
    last_nx  = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    code_nx  = ERR_NONE;
    if (recv_done) begin
      case (state_r)
        ST_IDLE: begin
          if (recv_data == 8'h55) begin
            state_nx = ST_HDR2;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_HDR2: begin
          if (recv_data == 8'hAA) begin
            state_nx = ST_LEN;
          end else if (recv_data == 8'h55) begin
            state_nx = ST_HDR2;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_LEN: begin
          if ((recv_data == 8'h00) || (recv_data > MAX_LEN_B)) begin
            err_nx   = 1'b1;
            code_nx  = ERR_LEN;
            state_nx = ST_IDLE;
          end else begin
            len_nx   = recv_data;
            idx_nx   = 8'h00;
`ifdef UART_FRAME_CHKSUM_EN
            sum_nx   = recv_data;
`endif
            state_nx = ST_DATA;
          end
        end
        ST_DATA: begin
          valid_nx = 1'b1;
          data_nx  = recv_data;
`ifdef UART_FRAME_CHKSUM_EN
          sum_nx   = chk_add(sum_r, recv_data);
`endif
          if (idx_r == (len_r - 8'd1)) begin
            last_nx  = 1'b1;
`ifdef UART_FRAME_CHKSUM_EN
            state_nx = ST_CHK;
`else
            done_nx  = 1'b1;
            state_nx = ST_IDLE;
`endif
          end else begin
            idx_nx   = idx_r + 8'd1;
          end
        end
`ifdef UART_FRAME_CHKSUM_EN
        ST_CHK: begin
          if (recv_data == sum_r) begin
            done_nx = 1'b1;
          end else begin
            err_nx  = 1'b1;
            code_nx = ERR_CHK;
          end
          state_nx = ST_IDLE;
        end
`endif
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end else if (tmo_hit) begin
      err_nx   = 1'b1;
      code_nx  = ERR_TMO;
      state_nx = ST_IDLE;
    end else begin
      state_nx = state_r;
    end
  end

  // Inter-byte timeout counter: only runs while a frame is in progress.
  always_comb begin
    if (recv_done || (state_r == ST_IDLE) || tmo_hit) begin
      tmo_nx = '0;
    end else begin
      tmo_nx = tmo_r + TMO_W'(1);
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      len_r      <= 8'h00;
      idx_r      <= 8'h00;
      tmo_r      <= '0;
`ifdef UART_FRAME_CHKSUM_EN
      sum_r      <= 8'h00;
`endif
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      len_r      <= len_nx;
      idx_r      <= idx_nx;
      tmo_r      <= tmo_nx;
`ifdef UART_FRAME_CHKSUM_EN
      sum_r      <= sum_nx;
`endif
      out_valid  <= valid_nx;
      out_data   <= data_nx;
      out_last   <= last_nx;
      frame_done <= done_nx;
      frame_err  <= err_nx;
      err_code   <= code_nx;
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser; follows UART_FRAME_CHKSUM_EN like the design does.
module tb_uart_frame_parser;

  localparam int CLK_FREQ   = 65_000_000;
  localparam int MAX_LEN    = 16;
  localparam int TIMEOUT_US = 2;
  localparam int LIMIT      = CLK_FREQ / 1_000_000 * TIMEOUT_US;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       recv_done = 1'b0;
  logic [7:0] recv_data = 8'h00;
  logic       out_valid, out_last, frame_done, frame_err;
  logic [7:0] out_data;
  logic [1:0] err_code;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       dn;
    logic       er;
    logic [1:0] c;
  } ev_t;

  ev_t        expq[$];
  ev_t        mon_e;
  logic [7:0] pl[$];
  int         checks = 0;
  int         errors = 0;

  uart_frame_parser #(
    .CLK_FREQ  (CLK_FREQ),
    .MAX_LEN   (MAX_LEN),
    .TIMEOUT_US(TIMEOUT_US)
  ) u_dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .recv_done (recv_done),
    .recv_data (recv_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Every output event is matched against the oldest expected event.
  always @(negedge sys_clk) begin
    if (!frame_err) check_eq("err_code_quiet", 32'(err_code), 32'd0);
    if (out_valid || frame_done || frame_err) begin
      if (expq.size() == 0) begin
        check_eq("unexpected_event", 32'({out_valid, frame_done, frame_err}), 32'd0);
      end else begin
        mon_e = expq.pop_front();
        check_eq("out_valid", 32'(out_valid), 32'(mon_e.v));
        if (mon_e.v) check_eq("out_data", 32'(out_data), 32'(mon_e.d));
        check_eq("out_last", 32'(out_last), 32'(mon_e.l));
        check_eq("frame_done", 32'(frame_done), 32'(mon_e.dn));
        check_eq("frame_err", 32'(frame_err), 32'(mon_e.er));
        check_eq("err_code", 32'(err_code), 32'(mon_e.c));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge sys_clk);
    recv_done = 1'b1;
    recv_data = b;
    @(negedge sys_clk);
    recv_done = 1'b0;
    recv_data = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push_ev(input logic v, input logic [7:0] d, input logic l,
                         input logic dn, input logic er, input logic [1:0] c);
    ev_t e;
    e.v = v; e.d = d; e.l = l; e.dn = dn; e.er = er; e.c = c;
    expq.push_back(e);
  endtask

  task automatic push_byte(input logic [7:0] d, input logic last);
`ifdef UART_FRAME_CHKSUM_EN
    push_ev(1'b1, d, last, 1'b0, 1'b0, 2'b00);
`else
    push_ev(1'b1, d, last, last, 1'b0, 2'b00);
`endif
  endtask

  // LEN, payload from pl, and the checksum byte when enabled.
  task automatic frame_body();
    logic [7:0] sum;
    sum = 8'(pl.size());
    send(8'(pl.size()));
    foreach (pl[i]) begin
      sum = sum + pl[i];
      push_byte(pl[i], i == pl.size() - 1);
      send(pl[i]);
    end
`ifdef UART_FRAME_CHKSUM_EN
    push_ev(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00);
    send(sum);
`endif
  endtask

  task automatic good_frame();
    send(8'h55);
    send(8'hAA);
    frame_body();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    idle(2);
    check_eq(tag, 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_data"}, 32'(out_data), 32'd0);
    check_eq({tag, "_last"}, 32'(out_last), 32'd0);
    check_eq({tag, "_done"}, 32'(frame_done), 32'd0);
    check_eq({tag, "_err"}, 32'(frame_err), 32'd0);
    check_eq({tag, "_code"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    sys_rst_n = 1'b1;
    #1 sys_rst_n = 1'b0;
    #3 check_outputs_zero("reset");
    idle(2);
    sys_rst_n = 1'b1;
    idle(2);
    check_outputs_zero("post_reset");

    // Main frame 55 AA 03 11 22 33 (69)
    pl = {8'h11, 8'h22, 8'h33};
    good_frame();
    drain("drain_basic", 20);

`ifdef UART_FRAME_CHKSUM_EN
    // Checksum mismatch: 55 AA 02 01 02 00
    send(8'h55); send(8'hAA); send(8'h02);
    push_byte(8'h01, 1'b0); send(8'h01);
    push_byte(8'h02, 1'b1); send(8'h02);
    push_ev(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'b10);
    send(8'h00);
    drain("drain_chk_err", 20);
`endif

    // Length zero and length above MAX_LEN
    push_ev(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'b01);
    send(8'h55); send(8'hAA); send(8'h00);
    drain("drain_len0", 20);
    push_ev(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'b01);
    send(8'h55); send(8'hAA); send(8'h11);
    drain("drain_len17", 20);

    // Length exactly MAX_LEN is accepted
    pl = {};
    for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'(i + 1));
    good_frame();
    drain("drain_maxlen", 20);

    // Repeated 0x55 header byte
    send(8'h55); send(8'h55); send(8'hAA);
    pl = {8'h7E};
    frame_body();
    drain("drain_hdr_repeat", 20);

    // Noise and a broken header produce nothing
    send(8'h12); send(8'h55); send(8'h34); send(8'hAA); send(8'h01);
    drain("drain_noise", 20);

    // Timeout mid-frame, fired once, then recovery
    send(8'h55); send(8'hAA); send(8'h04);
    push_byte(8'h01, 1'b0); send(8'h01);
    push_ev(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'b11);
    drain("drain_timeout", LIMIT + 20);
    idle(LIMIT + 10);
    pl = {8'hA5, 8'h5A};
    good_frame();
    drain("drain_after_timeout", 20);

    // Byte landing on the expiry cycle wins over the timeout
    send(8'h55); send(8'hAA); send(8'h01);
    idle(LIMIT - 2);
    push_byte(8'h7E, 1'b1);
    send(8'h7E);
`ifdef UART_FRAME_CHKSUM_EN
    push_ev(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00);
    send(8'h7F);
`endif
    drain("drain_tmo_tie", 20);

    // Reset mid-frame, then a normal frame
    send(8'h55); send(8'hAA); send(8'h02);
    push_byte(8'h01, 1'b0); send(8'h01);
    drain("drain_pre_reset", 20);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #2 check_outputs_zero("mid_reset");
    idle(3);
    sys_rst_n = 1'b1;
    idle(2);
    check_outputs_zero("after_mid_reset");
    pl = {8'h09};
    good_frame();
    drain("drain_post_reset", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
